// File: rtl/free_list_pkg.sv
// Shared rename-stage package (rename_pkg): sizes, tag type and the
// circular-pointer helper used by the free list.
package rename_pkg;
  localparam int ARCH_COUNT = 32;
  localparam int PHYS_REGS  = 64;
  localparam int N          = 3;
  localparam int PRW        = (PHYS_REGS <= 2) ? 1 : $clog2(PHYS_REGS);
  localparam int D          = PHYS_REGS - ARCH_COUNT;
  localparam int PTRW       = (D <= 2) ? 1 : $clog2(D);
  localparam int CNTW       = $clog2(D + 1);
  localparam int RKW        = $clog2(N + 1);

  typedef logic [PRW-1:0]  PR_TAG;
  typedef logic [PTRW-1:0] ptr_t;
  typedef logic [CNTW-1:0] cnt_t;
  typedef logic [RKW-1:0]  rank_t;

  // D need not be a power of two, so wrap with an explicit modulo.
  function automatic ptr_t ptr_add(input ptr_t p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    return ptr_t'(s % 32'(D));
  endfunction
endpackage

// File: rtl/free_list_if.sv
// Dispatch/retire/recovery signal bundle between rename and the free list.
interface free_list_if;
  import rename_pkg::*;
  logic              BPRecoverEN;
  logic [N-1:0]      alloc_req;
  logic [N-1:0]      alloc_valid;
  PR_TAG [N-1:0]     alloc_pr;
  logic [N-1:0]      free_en;
  PR_TAG [N-1:0]     free_pr;
  cnt_t              free_count;

  modport master (output BPRecoverEN, alloc_req, free_en, free_pr,
                  input  alloc_valid, alloc_pr, free_count);
  modport slave  (input  BPRecoverEN, alloc_req, free_en, free_pr,
                  output alloc_valid, alloc_pr, free_count);
endinterface

// File: rtl/free_list_lane_rank.sv
// Oldest-first prefix rank per lane (lane N-1 oldest) plus total popcount.
module lane_rank import rename_pkg::*; (
  input  logic [N-1:0]  mask_i,
  output rank_t [N-1:0] rank_o,
  output rank_t         total_o
);
  rank_t acc;

  always_comb begin
    acc    = '0;
    rank_o = '0;
    for (int i = N-1; i >= 0; i--) begin
      rank_o[i] = acc;
      acc       = acc + rank_t'(mask_i[i]);
    end
    total_o = acc;
  end
endmodule

// File: rtl/free_list.sv
// Circular physical-tag free list: N-wide alloc/free, one-cycle recovery.
// FREE_LIST_CHECK_EN adds a sticky `err` for overflow / double free.
module free_list import rename_pkg::*; (
  input logic        clock,
  input logic        reset,
  free_list_if.slave fl
`ifdef FREE_LIST_CHECK_EN
  , output logic     err
`endif
);
  PR_TAG        entries_q [D];
  PR_TAG        entries_d [D];
  ptr_t         head_q, head_d, tail_q, tail_d, rhead_q, rhead_d;
  cnt_t         count_q, count_d, grants, nfree;
  rank_t [N-1:0] arank, frank;
  rank_t        atotal, ftotal;
  logic [N-1:0] fen_acc;

  lane_rank u_arank (.mask_i(fl.alloc_req), .rank_o(arank), .total_o(atotal));
  lane_rank u_frank (.mask_i(fl.free_en),   .rank_o(frank), .total_o(ftotal));

  assign fl.free_count = count_q;

  always_comb begin
    fl.alloc_valid = '0;
    fl.alloc_pr    = '0;
    grants         = '0;
    for (int i = 0; i < N; i++) begin
      if (fl.alloc_req[i] && !fl.BPRecoverEN && int'(arank[i]) < int'(count_q)) begin
        fl.alloc_valid[i] = 1'b1;
        fl.alloc_pr[i]    = entries_q[ptr_add(head_q, 32'(arank[i]))];
      end
    end
    if (!fl.BPRecoverEN)
      grants = (int'(atotal) < int'(count_q)) ? cnt_t'(atotal) : count_q;
  end

`ifdef FREE_LIST_CHECK_EN
  int   room;
  logic ovf, dbl, err_q;

  // Frees beyond the remaining room are dropped; rank keeps survivors contiguous.
  always_comb begin
    room    = D - int'(count_q) + int'(grants);
    fen_acc = '0;
    nfree   = '0;
    dbl     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (fl.free_en[i] && int'(frank[i]) < room) begin
        fen_acc[i] = 1'b1;
        nfree      = nfree + cnt_t'(1);
      end
    end
    ovf = int'(ftotal) > room;
    for (int e = 0; e < D; e++) begin
      if ((e - int'(head_q) + D) % D < int'(count_q)) begin
        for (int j = 0; j < N; j++)
          if (fl.free_en[j] && entries_q[e] == fl.free_pr[j]) dbl = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | ovf | dbl;
  end
  assign err = err_q;
`else
  always_comb begin
    fen_acc = fl.free_en;
    nfree   = cnt_t'(ftotal);
  end
`endif

  always_comb begin
    entries_d = entries_q;
    for (int j = 0; j < N; j++)
      if (fen_acc[j]) entries_d[ptr_add(tail_q, 32'(frank[j]))] = fl.free_pr[j];
    tail_d  = ptr_add(tail_q, 32'(nfree));
    rhead_d = ptr_add(rhead_q, 32'(nfree));
    if (fl.BPRecoverEN) begin
      // Everything allocated past the retire point returns to the list.
      head_d  = rhead_d;
      count_d = cnt_t'(D);
    end else begin
      head_d  = ptr_add(head_q, 32'(grants));
      count_d = count_q - grants + nfree;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < D; i++) entries_q[i] <= PR_TAG'(ARCH_COUNT + i);
      head_q  <= '0;
      tail_q  <= '0;
      rhead_q <= '0;
      count_q <= cnt_t'(D);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      rhead_q   <= rhead_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vector table, corner sequences, and a
// randomized run against a FIFO model of the free tags.
module tb_free_list;
  import rename_pkg::*;

  logic clock, reset;
  free_list_if fl();
`ifdef FREE_LIST_CHECK_EN
  logic err;
`endif

  free_list dut (
    .clock(clock),
    .reset(reset),
    .fl(fl)
`ifdef FREE_LIST_CHECK_EN
    , .err(err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit            rst;
    logic [N-1:0]  req;
    logic [N-1:0]  fen;
    PR_TAG [N-1:0] fpr;
    bit            rec;
    logic [N-1:0]  ev;
    PR_TAG [N-1:0] epr;
    int            ecnt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mkv(bit rst, logic [2:0] req, logic [2:0] fen,
                               int f2, int f1, int f0, bit rec, logic [2:0] ev,
                               int e2, int e1, int e0, int ecnt);
    vec_t v;
    v.rst = rst; v.req = req; v.fen = fen; v.rec = rec; v.ev = ev; v.ecnt = ecnt;
    v.fpr = {PR_TAG'(f2), PR_TAG'(f1), PR_TAG'(f0)};
    v.epr = {PR_TAG'(e2), PR_TAG'(e1), PR_TAG'(e0)};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fl.alloc_req = '0; fl.free_en = '0; fl.free_pr = '0; fl.BPRecoverEN = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic apply_vec(input string nm, input vec_t v);
    if (v.rst) do_reset();
    @(negedge clock);
    fl.alloc_req = v.req; fl.free_en = v.fen; fl.free_pr = v.fpr; fl.BPRecoverEN = v.rec;
    #1;
    check({nm, " alloc_valid"}, 64'(fl.alloc_valid), 64'(v.ev));
    check({nm, " alloc_pr"},    64'(fl.alloc_pr),    64'(v.epr));
    check({nm, " free_count"},  64'(fl.free_count),  64'(v.ecnt));
    @(posedge clock);
  endtask

  vec_t   tbl [$];
  PR_TAG  fq [$];
  PR_TAG  inuse [$];
  PR_TAG  gl [$];
  PR_TAG  frl [$];
  logic [N-1:0]  req, fen, ev;
  PR_TAG [N-1:0] fpr, epr;
  int lim, k, idx;

  initial begin
    reset = 1'b0;
    fl.alloc_req = '0; fl.free_en = '0; fl.free_pr = '0; fl.BPRecoverEN = 1'b0;

    // Directed table: reset grants, sparse requests, recovery.
    tbl.push_back(mkv(1, 3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32, 33, 34, 32));
    tbl.push_back(mkv(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000,  0,  0,  0, 29));
    tbl.push_back(mkv(1, 3'b101, 3'b000, 0, 0, 0, 0, 3'b101, 32,  0, 33, 32));
    tbl.push_back(mkv(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000,  0,  0,  0, 30));
    tbl.push_back(mkv(1, 3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32, 33, 34, 32));
    tbl.push_back(mkv(0, 3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 35, 36, 37, 29));
    tbl.push_back(mkv(0, 3'b111, 3'b100, 3, 0, 0, 1, 3'b000,  0,  0,  0, 26));
    tbl.push_back(mkv(0, 3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 33, 34, 35, 32));
    // Frees from lanes 1,0 land oldest first after the current contents.
    tbl.push_back(mkv(0, 3'b010, 3'b011, 0, 9, 10, 0, 3'b010, 0, 36, 0, 29));
    tbl.push_back(mkv(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000,  0,  0,  0, 30));
    foreach (tbl[i]) apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Drain to empty, then a free into an empty list grants only next cycle.
    do_reset();
    for (int c = 0; c < 10; c++)
      apply_vec($sformatf("drain%0d", c),
                mkv(0, 3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32+3*c, 33+3*c, 34+3*c, 32-3*c));
    apply_vec("partial", mkv(0, 3'b111, 3'b000, 0, 0, 0, 0, 3'b110, 62, 63, 0, 2));
    apply_vec("empty",   mkv(0, 3'b111, 3'b000, 0, 0, 0, 0, 3'b000,  0,  0, 0, 0));
    apply_vec("nobypass",mkv(0, 3'b111, 3'b110, 5, 7, 0, 0, 3'b000,  0,  0, 0, 0));
    apply_vec("refill",  mkv(0, 3'b111, 3'b000, 0, 0, 0, 0, 3'b110,  5,  7, 0, 2));

    // Randomized alloc/free traffic against a FIFO of free tags.
    do_reset();
    fq.delete(); inuse.delete();
    for (int t = 0; t < D; t++) fq.push_back(PR_TAG'(ARCH_COUNT + t));
    for (int t = 1; t < ARCH_COUNT; t++) inuse.push_back(PR_TAG'(t));
    for (int c = 0; c < 600; c++) begin
      req = N'($urandom);
      lim = D - fq.size();
      if (inuse.size() < lim) lim = inuse.size();
      fen = '0; fpr = '0; k = 0; frl.delete();
      for (int i = N-1; i >= 0; i--) begin
        if ($urandom_range(0, 1) == 1 && k < lim) begin
          idx = $urandom_range(0, inuse.size()-1);
          fen[i] = 1'b1;
          fpr[i] = inuse[idx];
          frl.push_back(inuse[idx]);
          inuse.delete(idx);
          k++;
        end
      end
      ev = '0; epr = '0; k = 0; gl.delete();
      for (int i = N-1; i >= 0; i--) begin
        if (req[i]) begin
          if (k < fq.size()) begin
            ev[i]  = 1'b1;
            epr[i] = fq[k];
            gl.push_back(fq[k]);
          end
          k++;
        end
      end
      @(negedge clock);
      fl.alloc_req = req; fl.free_en = fen; fl.free_pr = fpr; fl.BPRecoverEN = 1'b0;
      #1;
      check($sformatf("rnd%0d alloc_valid", c), 64'(fl.alloc_valid), 64'(ev));
      check($sformatf("rnd%0d alloc_pr", c),    64'(fl.alloc_pr),    64'(epr));
      check($sformatf("rnd%0d free_count", c),  64'(fl.free_count),  64'(fq.size()));
      @(posedge clock);
      foreach (gl[i]) begin
        void'(fq.pop_front());
        inuse.push_back(gl[i]);
      end
      foreach (frl[i]) fq.push_back(frl[i]);
    end

    // Reset in the middle of traffic discards everything.
    apply_vec("midreset", mkv(1, 3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32, 33, 34, 32));

`ifdef FREE_LIST_CHECK_EN
    do_reset();
    #1 check("err after reset", 64'(err), 64'(0));
    apply_vec("overflow", mkv(0, 3'b000, 3'b100, 3, 0, 0, 0, 3'b000, 0, 0, 0, 32));
    #1 check("err raised", 64'(err), 64'(1));
    apply_vec("saturate", mkv(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32));
    #1 check("err sticky", 64'(err), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage: a circular buffer of unallocated physical tags. At dispatch it supplies up to N new tags per cycle, which feed the map table's new-PR inputs. At retire it reclaims up to N old tags (the map table's Told values). On branch recovery it rolls the allocation pointer back to the retire-side pointer in one cycle, so the list matches the architectural map table.

## Interface
- ARCH_COUNT, 32, architectural registers.
- PHYS_REGS, 64, physical registers; capacity D = PHYS_REGS - ARCH_COUNT.
- N, 3, lanes per cycle; lane N-1 oldest, lane 0 youngest.
- PRW, derived, $clog2(PHYS_REGS) (1 if PHYS_REGS <= 2).
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- BPRecoverEN  in  1  mispredict recovery; same cycle as the map table's copy from the architectural map.
- alloc_req  in  N  lane needs a new tag (dest != x0).
- alloc_valid  out  N  tag granted to lane.
- alloc_pr  out  N×PRW  granted tag; '0 when not valid.
- free_en  in  N  retiring lane frees its Told (dest != x0).
- free_pr  in  N×PRW  Told being freed.
- free_count  out  $clog2(D+1)  registered number of free entries.

## Operation
- Storage: entries[0..D-1] of PRW bits; head, tail, retire_head are indices mod D; count is 0..D.
- Allocation:
  - Requesting lanes are compacted oldest first. The k-th requesting lane (k = 0 for the oldest requester) gets entries[(head+k) mod D] if k < count.
  - Requesting lanes with k >= count get alloc_valid = 0; nothing partial or reordered.
  - head advances by the number of grants.
- Free:
  - Each free_en lane writes free_pr to entries[(tail+j) mod D], where j is its oldest-first rank among the freeing lanes.
  - tail and retire_head both advance by popcount(free_en).
- count_next = count − grants + frees.
- Recovery (BPRecoverEN=1):
  - The cycle's grants are suppressed: alloc_valid = 0, alloc_pr = '0.
  - The cycle's frees are still applied.
  - head ← retire_head + popcount(free_en), and count ← D.
- Priority: reset > BPRecoverEN > normal.
- free_pr values are not inspected; keeping x0/tag 0 out of free_en is the retire stage's responsibility.

## Timing
- Reset values:
  - entries[i] = ARCH_COUNT+i.
  - head = tail = retire_head = 0; count = D, so free_count = D.
  - alloc_valid = 0 and alloc_pr = 0 unless requested.
- alloc_valid and alloc_pr are combinational from registered head, count and entries in the same cycle as alloc_req (zero latency).
- Tags freed in cycle t are allocatable from cycle t+1; there is no same-cycle bypass, so a free into an empty list does not grant that cycle.
- free_count reflects state at the start of the cycle.
- Wrap-around: all pointer arithmetic is mod D; D need not be a power of two.
- Reset asserted mid-operation discards all state on that edge.

## Configuration
- FREE_LIST_CHECK_EN defined adds output `err` (1 bit, reset 0). `err` is sticky high on either:
  - count − grants + popcount(free_en) > D (overflow);
  - a freed tag equal to any currently free entry (double free).
- On overflow the excess frees are dropped and count saturates at D.
- Undefined: no `err` port and no checks; overflow behaviour is unspecified.

## Structure
- Shared package rename_pkg holds:
  - ARCH_COUNT, PHYS_REGS, N;
  - PR_TAG typedef (logic [PRW-1:0]);
  - the D constant.
- Sub-module lane_rank: N-bit mask in; per-lane oldest-first prefix rank and total popcount out. Instantiated twice, once for alloc_req and once for free_en.

## Test plan
- Reset, then alloc_req=111 → alloc_pr[2]=32, alloc_pr[1]=33, alloc_pr[0]=34, all valid; next cycle free_count=29.
- From reset, alloc_req=101 → lane2 gets 32, lane0 gets 33, lane1 alloc_valid=0 with alloc_pr=0; free_count=30.
- Ten cycles of 111 leave count=2; then 111 → lanes 2,1 valid, lane 0 not; free_count=0; a further 111 gives alloc_valid=000.
- At count=0: free_en=110 with free_pr 5,7 and alloc_req=111 → no grants that cycle; next cycle alloc_pr[2]=5, alloc_pr[1]=7, lane 0 invalid.
- After allocating 32..37: BPRecoverEN=1, free_en=100 with free_pr[2]=3, alloc_req=111 → alloc_valid=000; next cycle free_count=32 and alloc_pr[2]=33 (the recovered head skips the retired allocation 32; freed tag 3 occupies slot 0).
- Wrap and check: interleave allocs and frees through more than 2·D tags and compare every grant against a FIFO model. With FREE_LIST_CHECK_EN, a free at count=D raises `err`, and `err` stays high.
